// File: rtl/tlul_host_pkg.sv
// Shared types for the TL-UL host engine: TL-UL channel structs, the host
// command/response records, the A-side FSM state and the ID width.
package tlul_host_pkg;

  localparam int MaxOutstandingLimit = 16;
  localparam int IdW = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [1:0]  size;
  } host_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [7:0]  source;
    logic        error;
    logic        mismatch;
  } host_rsp_t;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_REQ  = 1'b1
  } a_state_e;

  // Response opcode a device must return for a given request kind.
  function automatic tl_d_op_e exp_d_op(input logic write);
    tl_d_op_e op;
    if (write) op = AccessAck;
    else       op = AccessAckData;
    return op;
  endfunction

endpackage

// File: rtl/tlul_host_id_alloc.sv
// Source-ID pool: busy bit per ID, lowest-free priority encoder and an
// in-flight counter. Availability is taken from registered state only.
module tlul_host_id_alloc
  import tlul_host_pkg::*;
#(
  parameter int MaxOutstanding = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_i,
  input  logic                      free_i,
  input  logic [IdW-1:0]            free_id_i,
  output logic                      avail_o,
  output logic [IdW-1:0]            id_o,
  output logic [4:0]                count_o,
  output logic [MaxOutstanding-1:0] busy_o
);

  logic [MaxOutstanding-1:0] busy_q, busy_d;
  logic [4:0]                count_q;
  logic                      do_alloc, do_free;

  always_comb begin
    avail_o = 1'b0;
    id_o    = '0;
    for (int i = MaxOutstanding - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        avail_o = 1'b1;
        id_o    = IdW'(i);
      end
    end
  end

  assign do_alloc = alloc_i && avail_o;

  // Free and allocate touch different IDs, since only free IDs are allocated.
  always_comb begin
    busy_d  = busy_q;
    do_free = 1'b0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (free_i && busy_q[i] && (free_id_i == IdW'(i))) begin
        busy_d[i] = 1'b0;
        do_free   = 1'b1;
      end
      if (do_alloc && (id_o == IdW'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q <= busy_d;
      unique case ({do_alloc, do_free})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/tlul_host_engine.sv
// TL-UL host: command stream -> A-channel requests, D responses -> response
// stream with opcode/size/source checking. Watchdog: TLUL_HOST_ENGINE_TIMEOUT_EN.
module tlul_host_engine
  import tlul_host_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter int SourceBase     = 0,
  parameter int TimeoutCycles  = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_mask_i,
  input  logic [1:0]  cmd_size_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [7:0]  rsp_source_o,
  output logic        rsp_error_o,
  output logic        rsp_mismatch_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i,
  output logic [4:0]  outstanding_o,
  output logic        timeout_o
);

  localparam logic [7:0] SrcBase  = 8'(SourceBase);
  localparam logic [7:0] PoolSize = 8'(MaxOutstanding);

  a_state_e                  state_q, state_d;
  host_cmd_t                 cmd, a_q;
  tl_a_op_e                  a_opcode_q;
  logic [7:0]                a_source_q;
  logic                      cmd_ready, a_valid, cmd_acc, a_hs;
  logic                      d_ready, d_hs, id_free;
  logic                      avail;
  logic [IdW-1:0]            alloc_id;
  logic [MaxOutstanding-1:0] busy;
  logic                      wr_tbl   [MaxOutstanding];
  logic [1:0]                size_tbl [MaxOutstanding];
  logic [8:0]                src_diff;
  logic                      in_range, hit, hit_wr, mismatch;
  logic [1:0]                hit_size;
  host_rsp_t                 rsp_p1;
  logic                      vld_p1;
  logic                      unused_tl;

  assign cmd = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i,
                 mask: cmd_mask_i, size: cmd_size_i};

  assign cmd_acc = cmd_valid_i && cmd_ready;
  assign a_hs    = a_valid && tl_i.a_ready;
  assign d_ready = !vld_p1 || rsp_ready_i;
  assign d_hs    = tl_i.d_valid && d_ready;
  assign id_free = d_hs && hit;

  tlul_host_id_alloc #(
    .MaxOutstanding(MaxOutstanding)
  ) u_id_alloc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .alloc_i   (cmd_acc),
    .free_i    (id_free),
    .free_id_i (src_diff[IdW-1:0]),
    .avail_o   (avail),
    .id_o      (alloc_id),
    .count_o   (outstanding_o),
    .busy_o    (busy)
  );

  // ---- A channel: state register / next state / outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= A_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A_IDLE: if (cmd_valid_i && cmd_ready) state_d = A_REQ;
      A_REQ:  if (tl_i.a_ready)             state_d = A_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    a_valid   = 1'b0;
    unique case (state_q)
      A_IDLE: cmd_ready = avail;
      A_REQ:  a_valid   = 1'b1;
    endcase
  end

  assign cmd_ready_o = cmd_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q        <= '0;
      a_opcode_q <= PutFullData;
      a_source_q <= '0;
    end else if (cmd_acc) begin
      a_q        <= cmd;
      a_opcode_q <= cmd.write ? PutFullData : Get;
      a_source_q <= SrcBase + 8'(alloc_id);
    end
  end

  // Per-ID attributes are only meaningful while the busy bit is set.
  always_ff @(posedge clk_i) begin
    if (cmd_acc) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        if (alloc_id == IdW'(i)) begin
          wr_tbl[i]   <= cmd.write;
          size_tbl[i] <= cmd.size;
        end
      end
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = a_opcode_q;
    tl_o.a_size    = a_q.size;
    tl_o.a_source  = a_source_q;
    tl_o.a_address = a_q.addr;
    tl_o.a_mask    = a_q.mask;
    tl_o.a_data    = a_q.wdata;
    tl_o.d_ready   = d_ready;
  end

  // ---- D channel: source lookup and response checking
  assign src_diff = {1'b0, tl_i.d_source} - {1'b0, SrcBase};
  assign in_range = !src_diff[8] && (src_diff[7:0] < PoolSize);

  always_comb begin
    hit      = 1'b0;
    hit_wr   = 1'b0;
    hit_size = '0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (in_range && (src_diff[7:0] == 8'(i)) && busy[i]) begin
        hit      = 1'b1;
        hit_wr   = wr_tbl[i];
        hit_size = size_tbl[i];
      end
    end
  end

  assign mismatch = !hit || (tl_i.d_size != hit_size) ||
                    (tl_i.d_opcode != exp_d_op(hit_wr));

  // ---- response register stage (p1)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      rsp_p1 <= '0;
    end else if (d_hs) begin
      vld_p1          <= 1'b1;
      rsp_p1.rdata    <= (hit && hit_wr) ? 32'h0 : tl_i.d_data;
      rsp_p1.source   <= tl_i.d_source;
      rsp_p1.error    <= tl_i.d_error;
      rsp_p1.mismatch <= mismatch;
    end else if (rsp_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid_o    = vld_p1;
  assign rsp_rdata_o    = rsp_p1.rdata;
  assign rsp_source_o   = rsp_p1.source;
  assign rsp_error_o    = rsp_p1.error;
  assign rsp_mismatch_o = rsp_p1.mismatch;

  assign unused_tl = ^{tl_i.d_param, tl_i.d_sink};

`ifdef TLUL_HOST_ENGINE_TIMEOUT_EN
  localparam logic [31:0] ToLimit = 32'(TimeoutCycles);
  logic [31:0] wd_cnt;
  logic        wd_flag, wd_run;

  assign wd_run = (a_valid && !tl_i.a_ready) || (outstanding_o != 5'd0);

  // Any handshake counts as progress; the flag is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (a_hs || d_hs || !wd_run) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != ToLimit)          wd_cnt  <= wd_cnt + 32'd1;
      if (wd_cnt + 32'd1 >= ToLimit)  wd_flag <= 1'b1;
    end
  end

  assign timeout_o = wd_flag;
`else
  logic [31:0] unused_timeout;
  logic        unused_a_hs;
  assign unused_timeout = 32'(TimeoutCycles);
  assign unused_a_hs    = a_hs;
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_tlul_host_engine.sv
// Directed bench for tlul_host_engine: table of single round trips plus
// hand sequences for pool exhaustion, reordering, backpressure, reset, watchdog.
module tb_tlul_host_engine;
  import tlul_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_mask;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_mismatch;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_source;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;
  logic [4:0]  outstanding;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlul_host_engine #(
    .MaxOutstanding(4),
    .SourceBase    (0),
    .TimeoutCycles (50)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_write_i    (cmd_write),
    .cmd_addr_i     (cmd_addr),
    .cmd_wdata_i    (cmd_wdata),
    .cmd_mask_i     (cmd_mask),
    .cmd_size_i     (cmd_size),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_source_o   (rsp_source),
    .rsp_error_o    (rsp_error),
    .rsp_mismatch_o (rsp_mismatch),
    .tl_o           (tl_o),
    .tl_i           (tl_i),
    .outstanding_o  (outstanding),
    .timeout_o      (timeout)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [1:0]  size;
    logic [2:0]  d_op;
    logic [1:0]  d_size;
    logic [31:0] d_data;
    logic        d_err;
    logic [2:0]  exp_aop;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[7];
  int   ooo[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [1:0] size);
    logic done;
    done      = 1'b0;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    cmd_size  = size;
    cmd_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("cmd_accept_bound", 32'(done), 32'd1);
  endtask

  task automatic d_send(input logic [7:0] src, input logic [2:0] op, input logic [1:0] size,
                        input logic [31:0] data, input logic err);
    tl_i.d_valid  = 1'b1;
    tl_i.d_source = src;
    tl_i.d_opcode = tl_d_op_e'(op);
    tl_i.d_size   = size;
    tl_i.d_data   = data;
    tl_i.d_error  = err;
    step();
    tl_i.d_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd2, 3'd0, 2'd2, 32'h12345678, 1'b0,
                3'd0, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h10, 32'h0, 4'hF, 2'd2, 3'd1, 2'd2, 32'hDEADBEEF, 1'b0,
                3'd4, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h20, 32'h55AA55AA, 4'hF, 2'd2, 3'd0, 2'd1, 32'hFFFFFFFF, 1'b0,
                3'd0, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h10, 32'h0, 4'hF, 2'd2, 3'd1, 2'd2, 32'hCAFEF00D, 1'b1,
                3'd4, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h30, 32'h0, 4'hF, 2'd2, 3'd0, 2'd2, 32'h00000033, 1'b0,
                3'd4, 32'h00000033, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h21, 32'h000000AB, 4'h2, 2'd0, 3'd1, 2'd0, 32'h00000011, 1'b0,
                3'd0, 32'h0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h42, 32'h0, 4'hC, 2'd1, 3'd1, 2'd1, 32'h0000A5A5, 1'b0,
                3'd4, 32'h0000A5A5, 1'b0, 1'b0};
    ooo = '{3, 0, 2, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_mask = '0; cmd_size = '0; rsp_ready = 1'b1; tl_i = '0;
    step();
    step();
    chk("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
    chk("rst_a_opcode", 32'(tl_o.a_opcode), 32'd0);
    chk("rst_a_address", tl_o.a_address, 32'd0);
    chk("rst_a_source", 32'(tl_o.a_source), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_d_ready", 32'(tl_o.d_ready), 32'd1);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Table: one transaction each, device answers one cycle after a_ready.
    for (int k = 0; k < 7; k++) begin
      send_cmd(vecs[k].w, vecs[k].addr, vecs[k].wdata, vecs[k].mask, vecs[k].size);
      chk($sformatf("v%0d_a_valid", k), 32'(tl_o.a_valid), 32'd1);
      chk($sformatf("v%0d_a_opcode", k), 32'(tl_o.a_opcode), 32'(vecs[k].exp_aop));
      chk($sformatf("v%0d_a_address", k), tl_o.a_address, vecs[k].addr);
      chk($sformatf("v%0d_a_size", k), 32'(tl_o.a_size), 32'(vecs[k].size));
      chk($sformatf("v%0d_a_mask", k), 32'(tl_o.a_mask), 32'(vecs[k].mask));
      chk($sformatf("v%0d_a_data", k), tl_o.a_data, vecs[k].wdata);
      chk($sformatf("v%0d_a_source", k), 32'(tl_o.a_source), 32'd0);
      chk($sformatf("v%0d_outst_1", k), 32'(outstanding), 32'd1);
      tl_i.a_ready = 1'b1;
      step();
      tl_i.a_ready = 1'b0;
      chk($sformatf("v%0d_a_drop", k), 32'(tl_o.a_valid), 32'd0);
      d_send(8'd0, vecs[k].d_op, vecs[k].d_size, vecs[k].d_data, vecs[k].d_err);
      chk($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_rdata", k), rsp_rdata, vecs[k].exp_rdata);
      chk($sformatf("v%0d_source", k), 32'(rsp_source), 32'd0);
      chk($sformatf("v%0d_error", k), 32'(rsp_error), 32'(vecs[k].exp_err));
      chk($sformatf("v%0d_mismatch", k), 32'(rsp_mismatch), 32'(vecs[k].exp_mis));
      chk($sformatf("v%0d_outst_0", k), 32'(outstanding), 32'd0);
      step();
      chk($sformatf("v%0d_rsp_clear", k), 32'(rsp_valid), 32'd0);
    end

    // Full pool: four reads take sources 0..3, the fifth waits.
    tl_i.a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF, 2'd2);
      chk($sformatf("pool_src%0d", i), 32'(tl_o.a_source), 32'(i));
    end
    step();
    cmd_write = 1'b0; cmd_addr = 32'h200; cmd_size = 2'd2; cmd_mask = 4'hF; cmd_valid = 1'b1;
    #1;
    chk("full_cmd_ready_0", 32'(cmd_ready), 32'd0);
    repeat (20) step();
    chk("full_cmd_ready_20", 32'(cmd_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    d_send(8'd2, 3'd1, 2'd2, 32'h00000102, 1'b0);
    chk("free2_rsp_source", 32'(rsp_source), 32'd2);
    chk("free2_rdata", rsp_rdata, 32'h00000102);
    chk("free2_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("free2_outstanding", 32'(outstanding), 32'd3);
    chk("free2_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("realloc_src", 32'(tl_o.a_source), 32'd2);
    chk("realloc_addr", tl_o.a_address, 32'h200);
    chk("realloc_outst", 32'(outstanding), 32'd4);
    cmd_addr = 32'h204; cmd_valid = 1'b1;
    step();
    step();
    chk("sixth_blocked", 32'(cmd_ready), 32'd0);
    d_send(8'd0, 3'd1, 2'd2, 32'h00000100, 1'b0);
    chk("free0_rsp_source", 32'(rsp_source), 32'd0);
    chk("free0_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("sixth_src", 32'(tl_o.a_source), 32'd0);
    step();
    tl_i.a_ready = 1'b0;
    chk("refull_outst", 32'(outstanding), 32'd4);

    // Device answers out of order; source s carries data 0xA000_0000+s.
    for (int k = 0; k < 4; k++) begin
      d_send(8'(ooo[k]), 3'd1, 2'd2, 32'hA0000000 + 32'(ooo[k]), 1'b0);
      chk($sformatf("ooo%0d_source", k), 32'(rsp_source), 32'(ooo[k]));
      chk($sformatf("ooo%0d_rdata", k), rsp_rdata, 32'hA0000000 + 32'(ooo[k]));
      chk($sformatf("ooo%0d_mismatch", k), 32'(rsp_mismatch), 32'd0);
      chk($sformatf("ooo%0d_outst", k), 32'(outstanding), 32'(3 - k));
    end
    step();
    chk("ooo_rsp_clear", 32'(rsp_valid), 32'd0);

    // Unknown source frees nothing.
    tl_i.a_ready = 1'b1;
    send_cmd(1'b0, 32'h300, 32'h0, 4'hF, 2'd2);
    step();
    tl_i.a_ready = 1'b0;
    d_send(8'd7, 3'd1, 2'd2, 32'h00000077, 1'b0);
    chk("unk_mismatch", 32'(rsp_mismatch), 32'd1);
    chk("unk_source", 32'(rsp_source), 32'd7);
    chk("unk_outst", 32'(outstanding), 32'd1);
    d_send(8'd0, 3'd1, 2'd2, 32'h00000300, 1'b0);
    chk("known_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("known_outst", 32'(outstanding), 32'd0);
    step();

    // Response backpressure stalls the D channel.
    tl_i.a_ready = 1'b1;
    send_cmd(1'b0, 32'h400, 32'h0, 4'hF, 2'd2);
    send_cmd(1'b0, 32'h404, 32'h0, 4'hF, 2'd2);
    step();
    tl_i.a_ready = 1'b0;
    rsp_ready = 1'b0;
    d_send(8'd0, 3'd1, 2'd2, 32'h00000400, 1'b0);
    chk("bp_first_valid", 32'(rsp_valid), 32'd1);
    tl_i.d_valid = 1'b1; tl_i.d_source = 8'd1; tl_i.d_data = 32'h00000404;
    #1;
    chk("bp_d_ready_low", 32'(tl_o.d_ready), 32'd0);
    repeat (3) step();
    chk("bp_held_source", 32'(rsp_source), 32'd0);
    chk("bp_held_d_ready", 32'(tl_o.d_ready), 32'd0);
    chk("bp_held_outst", 32'(outstanding), 32'd1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_d_ready", 32'(tl_o.d_ready), 32'd1);
    step();
    tl_i.d_valid = 1'b0;
    chk("bp_second_source", 32'(rsp_source), 32'd1);
    chk("bp_second_rdata", rsp_rdata, 32'h00000404);
    chk("bp_outst", 32'(outstanding), 32'd0);
    step();
    chk("bp_rsp_clear", 32'(rsp_valid), 32'd0);

    // Reset while an A request is waiting for a_ready.
    send_cmd(1'b0, 32'h500, 32'h0, 4'hF, 2'd2);
    chk("mid_a_valid", 32'(tl_o.a_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_a_valid", 32'(tl_o.a_valid), 32'd0);
    chk("mid_rst_outst", 32'(outstanding), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    d_send(8'd0, 3'd1, 2'd2, 32'h00000500, 1'b0);
    chk("abandoned_valid", 32'(rsp_valid), 32'd1);
    chk("abandoned_mismatch", 32'(rsp_mismatch), 32'd1);
    chk("abandoned_outst", 32'(outstanding), 32'd0);
    step();

    // Watchdog: a_ready stuck low.
    send_cmd(1'b0, 32'h600, 32'h0, 4'hF, 2'd2);
    repeat (49) step();
    chk("wd_before", 32'(timeout), 32'd0);
    step();
`ifdef TLUL_HOST_ENGINE_TIMEOUT_EN
    chk("wd_at_limit", 32'(timeout), 32'd1);
`else
    chk("wd_disabled", 32'(timeout), 32'd0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wd_rst_clear", 32'(timeout), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlul_host_engine.md
Name: tlul_host_engine

Overview:
- Synthesisable, parametrised TL-UL host that turns a simple command stream into TL-UL A-channel requests and returns D-channel responses on a response stream.
- Supports up to MaxOutstanding in-flight transactions, with a_source allocation and full response checking: opcode, size, source.
- Used as a bus master for DMA/test engines, and as the cycle-accurate replacement for task-based bench hosts.

Parameters:
- MaxOutstanding, 4, in-flight transactions (1..16); sets the a_source ID pool.
- SourceBase, 0, first a_source value used; IDs are SourceBase..SourceBase+MaxOutstanding-1.
- TimeoutCycles, 1000, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_write_i  in  1  1=PutFullData, 0=Get
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  32  write data
- cmd_mask_i  in  4  byte mask
- cmd_size_i  in  2  log2 bytes (0..2)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  d_data (0 for writes)
- rsp_source_o  out  8  d_source of the response
- rsp_error_o  out  1  d_error from device
- rsp_mismatch_o  out  1  opcode/size/source check failed
- tl_o  out  tl_h2d_t  TL-UL request + d_ready
- tl_i  in  tl_d2h_t  TL-UL response + a_ready
- outstanding_o  out  5  count of in-flight transactions
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values (one cycle of rst_i high):
  - tl_o: a_valid=0, a_opcode=PutFullData, all other fields 0.
  - All ID entries are free; outstanding_o=0; rsp_valid_o=0; timeout_o=0.
  - rsp_* data outputs are 0.
  - d_ready follows its combinational rule below.
- A-channel FSM, states A_IDLE and A_REQ:
  - cmd_ready_o = (state==A_IDLE) && free ID exists, with free-ID state taken from registers.
  - On accept: register the A fields and allocate the lowest free ID into a_source, go to A_REQ with a_valid=1.
  - a_valid=1 and all A fields stay stable until a_ready=1, then return to A_IDLE.
  - Accept-to-a_valid latency is 1 cycle; maximum throughput is one request per 2 cycles.
- ID table, one entry per ID: busy, write, size.
  - Entry is set on command accept and cleared on D accept.
  - An ID freed in cycle N is allocatable from cycle N+1 only.
  - Allocation and free in the same cycle, on different IDs, are both honoured.
- D channel:
  - d_ready = !rsp_valid_o || rsp_ready_i, combinational; this is a 1-entry response register.
  - On d_valid&&d_ready:
    - Capture d_data (forced to 0 if the entry is a write), d_source and d_error.
    - mismatch = source not busy in the table, OR d_size != stored size, OR opcode wrong. The correct opcode is AccessAck for a write and AccessAckData for a read.
    - An unknown source frees nothing.
  - Responses are delivered in D arrival order; out-of-order responses from the device are legal.
- outstanding_o: +1 on command accept, -1 on D accept of a known source; both in one cycle leaves it unchanged. It never exceeds MaxOutstanding.
- Full condition: when outstanding_o==MaxOutstanding, cmd_ready_o=0 until a response frees an ID.
- Response backpressure: rsp_ready_i=0 holds d_ready=0 while rsp_valid_o=1; the device must stall.
- Reset mid-operation: all state is dropped and in-flight transactions are abandoned. A later D beat for an abandoned ID is accepted and flagged with mismatch.

Optional Feature:
- Macro: TLUL_HOST_ENGINE_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle while (a_valid && !a_ready) or outstanding_o!=0.
  - Counter clears on any A or D handshake, and while idle.
  - When the counter reaches TimeoutCycles, timeout_o is set; it is cleared only by rst_i.
  - Traffic continues after the flag is set.
- Undefined: no counter is built and timeout_o is tied to 0.

Decomposition:
- Package tlul_host_pkg:
  - host_cmd_t struct: write, addr, wdata, mask, size.
  - host_rsp_t struct: rdata, source, error, mismatch.
  - MaxOutstandingLimit = 16.
- Sub-module tlul_host_id_alloc:
  - Busy bit-vector with a lowest-free priority encoder.
  - Inputs alloc_i, free_i, free_id_i; outputs avail_o, id_o, count_o.

Test Plan:
- Single write, then read:
  - Stimulus: write 0x10 = 0xDEADBEEF, mask 0xF, size 2; then read 0x10. Device responds 1 cycle after a_ready.
  - Required: a_valid one cycle after accept; responses AccessAck then AccessAckData with rdata 0xDEADBEEF; mismatch=0; outstanding_o returns to 0.
- Full pool (MaxOutstanding=4):
  - Stimulus: 6 back-to-back reads; device withholds D for 20 cycles.
  - Required: a_source 0,1,2,3 issued; cmd_ready_o=0 with outstanding_o=4. After the first D (source 2), the next command gets source 2 one cycle later.
- Out-of-order responses:
  - Stimulus: device answers sources 3,0,2,1.
  - Required: rsp_source_o sequence 3,0,2,1 with correct rdata each; mismatch=0.
- Checks:
  - Stimulus: D for a write with d_size=1, then a D with unknown source 7, then d_error=1.
  - Required: mismatch=1, mismatch=1 with outstanding_o unchanged, then error=1 with mismatch=0.
- Backpressure and reset:
  - Stimulus: rsp_ready_i=0 with 2 responses pending, then assert rst_i mid-A-request.
  - Required: d_ready=0 while rsp held. After rst_i: a_valid=0, outstanding_o=0, rsp_valid_o=0 next cycle.
- Timeout (macro defined, TimeoutCycles=50):
  - Stimulus: read with a_ready stuck at 0.
  - Required: timeout_o=1 exactly 50 cycles after a_valid rises; with the macro undefined it stays 0.
